npc_ctrl: RTL and testbench
===========================

Name: npc_ctrl

Overview:
Multi-cycle sequencer for the NPC core datapath (PC register, regfile, immgen, ALU). It owns the PC, fetches instructions over a req/ready instruction-memory handshake, and decodes the supported subset (addi, add, ebreak). It drives regfile write-enable and ALU operand select, which were hard-wired in the single-cycle top. It halts on ebreak, illegal instruction or fetch timeout, and counts retired instructions.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset
FETCH_TIMEOUT, 16, max consecutive req-high/ready-low cycles before fetch fault (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address, always equals pc
imem_ready  in  1  fetch completes this cycle; imem_rdata valid
imem_rdata  in  32  fetched instruction word
pc  out  32  current instruction address
inst  out  32  latched instruction, feeds regfile/immgen decode
reg_we  out  1  regfile write enable
imm_sel  out  1  1 = ALU rs2 operand is sextimm, 0 = rs2
retire  out  1  one-cycle pulse per retired instruction
instret  out  32  retired-instruction counter
halt  out  1  sticky, core stopped
illegal  out  1  sticky, halted on unsupported instruction
fetch_err  out  1  sticky, halted on fetch timeout

Behaviour:
- States: IDLE, FETCH, EXEC, HALT.
- Reset (sync, priority over everything): state=IDLE, pc=RESET_PC, inst=0, instret=0, timeout counter=0; all 1-bit outputs 0. Reset asserted mid-fetch drops imem_req at the next edge.
- IDLE: one cycle, no outputs. Next state is FETCH.
- FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ready. imem_ready may arrive in the first FETCH cycle.
  - On imem_ready=1: inst<=imem_rdata, timeout counter<=0, go to EXEC.
  - Otherwise: counter increments. When the counter reaches FETCH_TIMEOUT, go to HALT with fetch_err=1 and halt=1; pc unchanged.
  - imem_ready outside FETCH is ignored.
- EXEC: one cycle, combinational decode of inst.
  - addi (opcode 0010011, funct3 000): imm_sel=1; reg_we=1 iff rd!=0.
  - add (opcode 0110011, funct3 000, funct7 0000000): imm_sel=0; reg_we=1 iff rd!=0.
  - On addi/add: retire=1, instret+=1 (wraps 2^32-1 -> 0), pc<=pc+4 (mod 2^32), next state FETCH.
  - ebreak (exactly 32'h00100073): reg_we=0, retire=1, instret+=1, pc unchanged, go to HALT with halt=1.
  - Any other encoding: reg_we=0, retire=0, pc unchanged, go to HALT with halt=1 and illegal=1.
- imm_sel is 1 in every state except EXEC with add. reg_we and retire are 0 outside EXEC.
- HALT: absorbing until rst. imem_req=0; pc, inst and instret frozen; the sticky flags hold.
- Latency: 2 cycles per instruction with zero-wait memory (FETCH+EXEC); each wait cycle adds 1.
- The register write lands at the edge ending EXEC, the same edge as the pc update.

Test Plan:
- Reset: hold rst 2 cycles, release. pc=80000000, all flags 0, instret=0. imem_req rises on the 2nd cycle after release (after IDLE).
- Zero-wait stream: imem_ready=1 constantly, 3x addi x1,x1,1 (00108093).
  - imem_addr sequence 80000000/04/08.
  - retire pulses every 2nd cycle; reg_we=1 and imm_sel=1 in EXEC; instret=3.
- Wait states plus add: ready delayed 3 cycles on add x5,x6,x7 (007302b3). req and addr stable for 4 cycles, then EXEC with imm_sel=0, reg_we=1. addi x0,x0,0 (00000013) retires with reg_we=0.
- ebreak after 2 addi: halt=1, illegal=0, instret=3, pc frozen at 80000008, imem_req=0 thereafter even with ready toggling.
- Illegal (32'h00000000) at pc 80000004: halt=1, illegal=1, retire never pulses for it, instret=1.
- Timeout and reset: ready held 0 with FETCH_TIMEOUT=4.
  - After 4 req cycles: fetch_err=1, halt=1.
  - Assert rst in HALT and also mid-FETCH: all state returns to reset values at the next edge.

Source files
------------

// File: rtl/npc_ctrl.sv
// Multi-cycle fetch/execute sequencer for the NPC core: owns the PC, fetches over a
// req/ready handshake, decodes addi/add/ebreak and counts retired instructions.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | one dead cycle out of reset
//   S_FETCH | imem_req high at pc, waiting for imem_ready (with timeout)
//   S_EXEC  | decode latched inst, drive reg_we/imm_sel, advance pc
//   S_HALT  | stopped until rst; sticky flags report why
module npc_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h80000000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        reg_we,
    output logic        imm_sel,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halt,
    output logic        illegal,
    output logic        fetch_err
);

    localparam int            CW     = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(FETCH_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_pc, w_pc_nxt;
    logic [31:0]   r_inst, w_inst_nxt;
    logic [31:0]   r_instret, w_instret_nxt;
    logic [CW-1:0] r_tcnt, w_tcnt_nxt;
    logic          r_halt, w_halt_nxt;
    logic          r_illegal, w_illegal_nxt;
    logic          r_fetch_err, w_fetch_err_nxt;

    logic [CW-1:0] w_tcnt_inc;
    logic [6:0]    w_opcode;
    logic [2:0]    w_funct3;
    logic [6:0]    w_funct7;
    logic [4:0]    w_rd;
    logic          w_is_addi;
    logic          w_is_add;
    logic          w_is_ebreak;

    assign w_tcnt_inc  = r_tcnt + CW'(1);
    assign w_opcode    = r_inst[6:0];
    assign w_rd        = r_inst[11:7];
    assign w_funct3    = r_inst[14:12];
    assign w_funct7    = r_inst[31:25];
    assign w_is_addi   = (w_opcode == 7'b0010011) && (w_funct3 == 3'b000);
    assign w_is_add    = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0000000);
    assign w_is_ebreak = (r_inst == 32'h00100073);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_inst      <= 32'h0;
            r_instret   <= 32'h0;
            r_tcnt      <= '0;
            r_halt      <= 1'b0;
            r_illegal   <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_inst      <= w_inst_nxt;
            r_instret   <= w_instret_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_halt      <= w_halt_nxt;
            r_illegal   <= w_illegal_nxt;
            r_fetch_err <= w_fetch_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_inst_nxt      = r_inst;
        w_instret_nxt   = r_instret;
        w_tcnt_nxt      = r_tcnt;
        w_halt_nxt      = r_halt;
        w_illegal_nxt   = r_illegal;
        w_fetch_err_nxt = r_fetch_err;
        imem_req        = 1'b0;
        reg_we          = 1'b0;
        imm_sel         = 1'b1;
        retire          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_inst_nxt  = imem_rdata;
                    w_tcnt_nxt  = '0;
                    w_state_nxt = S_EXEC;
                end else begin
                    w_tcnt_nxt = w_tcnt_inc;
                    if (w_tcnt_inc == TO_CNT) begin
                        w_state_nxt     = S_HALT;
                        w_halt_nxt      = 1'b1;
                        w_fetch_err_nxt = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (w_is_addi || w_is_add) begin
                    imm_sel       = w_is_addi;
                    reg_we        = (w_rd != 5'd0);
                    retire        = 1'b1;
                    w_instret_nxt = r_instret + 32'd1;
                    w_pc_nxt      = r_pc + 32'd4;
                    w_state_nxt   = S_FETCH;
                end else if (w_is_ebreak) begin
                    // ebreak counts as retired but leaves pc pointing at itself
                    retire        = 1'b1;
                    w_instret_nxt = r_instret + 32'd1;
                    w_state_nxt   = S_HALT;
                    w_halt_nxt    = 1'b1;
                end else begin
                    w_state_nxt   = S_HALT;
                    w_halt_nxt    = 1'b1;
                    w_illegal_nxt = 1'b1;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign inst      = r_inst;
    assign instret   = r_instret;
    assign halt      = r_halt;
    assign illegal   = r_illegal;
    assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_npc_ctrl.sv
// Randomized bench for npc_ctrl: an instruction-level model predicts every output each
// cycle, plus literal expectations for the directed programs.
module tb_npc_ctrl;

    localparam logic [31:0] RST_PC = 32'h80000000;
    localparam int          TO     = 4;
    localparam logic [31:0] ADDI1  = 32'h00108093;
    localparam logic [31:0] ADD567 = 32'h007302b3;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] EBRK   = 32'h00100073;

    localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc, inst, instret;
    logic        reg_we, imm_sel, retire, halt, illegal, fetch_err;

    npc_ctrl #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc(pc), .inst(inst), .reg_we(reg_we), .imm_sel(imm_sel),
        .retire(retire), .instret(instret),
        .halt(halt), .illegal(illegal), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_ret = 0;

    // model of the architectural state
    int          m_phase;
    logic [31:0] m_pc, m_inst, m_instret;
    int          m_tcnt;
    logic        m_halt, m_ill, m_fe;
    bit          m_valid = 0;

    logic [31:0] mem [16];
    int          waitq[$];
    int          wait_left = 0;
    bit          in_fetch  = 0;
    bit          rand_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // 1=addi 2=add 3=ebreak 0=anything else
    function automatic int kind(input logic [31:0] w);
        if (w == EBRK) return 3;
        if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) return 1;
        if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0) return 2;
        return 0;
    endfunction

    task automatic model_step(input logic r, input logic rdy, input logic [31:0] rd);
        int k;
        if (r) begin
            m_phase = P_IDLE; m_pc = RST_PC; m_inst = 0; m_instret = 0; m_tcnt = 0;
            m_halt = 0; m_ill = 0; m_fe = 0; m_valid = 1;
        end else if (m_valid) begin
            case (m_phase)
                P_IDLE: m_phase = P_FETCH;
                P_FETCH: begin
                    if (rdy) begin
                        m_inst = rd; m_tcnt = 0; m_phase = P_EXEC;
                    end else begin
                        m_tcnt++;
                        if (m_tcnt == TO) begin m_phase = P_HALT; m_halt = 1; m_fe = 1; end
                    end
                end
                P_EXEC: begin
                    k = kind(m_inst);
                    if (k == 1 || k == 2) begin
                        m_instret = m_instret + 1; m_pc = m_pc + 4; m_phase = P_FETCH;
                    end else if (k == 3) begin
                        m_instret = m_instret + 1; m_phase = P_HALT; m_halt = 1;
                    end else begin
                        m_phase = P_HALT; m_halt = 1; m_ill = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        int k;
        bit ex;
        k  = kind(m_inst);
        ex = (m_phase == P_EXEC);
        check("imem_req",  32'(imem_req),  32'(m_phase == P_FETCH));
        check("imem_addr", imem_addr, m_pc);
        check("pc",        pc,        m_pc);
        check("inst",      inst,      m_inst);
        check("reg_we",    32'(reg_we),  32'(ex && (k == 1 || k == 2) && m_inst[11:7] != 5'd0));
        check("imm_sel",   32'(imm_sel), 32'(!(ex && k == 2)));
        check("retire",    32'(retire),  32'(ex && k != 0));
        check("instret",   instret,   m_instret);
        check("halt",      32'(halt),      32'(m_halt));
        check("illegal",   32'(illegal),   32'(m_ill));
        check("fetch_err", 32'(fetch_err), 32'(m_fe));
        if (retire) n_ret++;
    endtask

    task automatic cycle(input logic r, input logic rdy, input logic [31:0] rd);
        rst = r; imem_ready = rdy; imem_rdata = rd;
        @(posedge clk);
        model_step(r, rdy, rd);
        #1;
        if (m_valid) compare_all();
    endtask

    function automatic int def_wait();
        if (!rand_mode) return 0;
        if ($urandom_range(0, 19) == 0) return 6;
        return $urandom_range(0, 3);
    endfunction

    task automatic drive_one();
        logic        rdy;
        logic [31:0] rd;
        if (m_phase == P_FETCH) begin
            if (!in_fetch) begin
                in_fetch  = 1;
                wait_left = (waitq.size() > 0) ? waitq.pop_front() : def_wait();
            end
            rdy = (wait_left == 0);
            if (wait_left > 0) wait_left--;
            rd = mem[m_pc[5:2]];
        end else begin
            in_fetch = 0;
            rdy = 1'($urandom_range(0, 1));
            rd  = $urandom;
        end
        cycle(1'b0, rdy, rd);
    endtask

    task automatic do_reset(input int n);
        waitq.delete();
        in_fetch = 0;
        for (int i = 0; i < n; i++) cycle(1'b1, 1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic run_prog(input int max_cyc, output int ncyc);
        ncyc = 0;
        while (m_phase != P_HALT && ncyc < max_cyc) begin
            drive_one();
            ncyc++;
        end
        check("halt_within_bound", 32'(m_phase == P_HALT && halt), 32'd1);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) drive_one();
    endtask

    task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
        for (int i = 0; i < 16; i++) mem[i] = EBRK;
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0] rd, rs1, rs2;
        rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        case ($urandom_range(0, 11))
            0, 1, 2, 3: return {12'($urandom), rs1, 3'b000, rd, 7'b0010011};
            4, 5, 6, 7: return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
            8:          return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            9:          return {12'($urandom), rs1, 3'b010, rd, 7'b0010011};
            10:         return 32'h0;
            default:    return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc, r0;

        // reset state and IDLE cycle
        load(ADDI1, ADDI1, ADDI1, EBRK);
        do_reset(2);
        check("rst_pc", pc, 32'h80000000);
        check("rst_instret", instret, 32'd0);
        check("rst_flags", {29'd0, halt, illegal, fetch_err}, 32'd0);
        check("rst_idle_req", 32'(imem_req), 32'd0);
        waitq = {0, 0, 0, 0};
        drive_one();
        check("req_2nd_cycle", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h80000000);

        // zero-wait stream: 3x addi then ebreak
        r0 = n_ret;
        run_prog(100, ncyc);
        check("zw_cycles", ncyc + 1, 32'd9);
        check("zw_retires", n_ret - r0, 32'd4);
        check("zw_instret", instret, 32'd4);
        check("zw_pc", pc, 32'h8000000C);

        // wait states on add, then addi x0 and ebreak
        load(ADD567, NOP, EBRK, EBRK);
        do_reset(2);
        waitq = {3, 0, 0};
        run_prog(100, ncyc);
        check("ws_cycles", ncyc, 32'd10);
        check("ws_instret", instret, 32'd3);
        check("ws_pc", pc, 32'h80000008);

        // ebreak after 2 addi, then ready toggling while halted
        load(ADDI1, ADDI1, EBRK, EBRK);
        do_reset(2);
        run_prog(100, ncyc);
        run_cycles(10);
        check("eb_cycles", ncyc, 32'd7);
        check("eb_halt", {30'd0, halt, illegal}, 32'd2);
        check("eb_instret", instret, 32'd3);
        check("eb_pc", pc, 32'h80000008);
        check("eb_req", 32'(imem_req), 32'd0);

        // illegal word at 80000004
        load(ADDI1, 32'h0, EBRK, EBRK);
        do_reset(1);
        r0 = n_ret;
        run_prog(100, ncyc);
        run_cycles(3);
        check("il_flags", {29'd0, halt, illegal, fetch_err}, 32'd6);
        check("il_instret", instret, 32'd1);
        check("il_retires", n_ret - r0, 32'd1);
        check("il_pc", pc, 32'h80000004);

        // fetch timeout, reset in HALT, reset mid-FETCH
        do_reset(2);
        waitq = {100};
        run_prog(100, ncyc);
        check("to_cycles", ncyc, 32'd5);
        check("to_flags", {29'd0, halt, illegal, fetch_err}, 32'd5);
        check("to_pc", pc, 32'h80000000);
        do_reset(1);
        check("to_rst_flags", {29'd0, halt, illegal, fetch_err}, 32'd0);
        check("to_rst_req", 32'(imem_req), 32'd0);
        waitq = {100};
        run_cycles(3);
        check("mid_req_before", 32'(imem_req), 32'd1);
        do_reset(1);
        check("mid_req_after", 32'(imem_req), 32'd0);
        check("mid_pc", pc, 32'h80000000);

        // randomized programs with random waits, timeouts and cut-short resets
        rand_mode = 1;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 16; i++) mem[i] = EBRK;
            for (int i = 0; i < $urandom_range(1, 12); i++) mem[i] = rand_inst();
            do_reset($urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) run_cycles($urandom_range(2, 30));
            else begin
                run_prog(400, ncyc);
                run_cycles($urandom_range(0, 4));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
